// File: rtl/alarm_sequencer_if.sv
// alarm_sequencer_if
//   Groups the anti-theft controller's sensor inputs, programming bus,
//   1 Hz divider handshake and status outputs into one bundle.
//   master : environment side (drives sensors, reprogram bus, one_hz_enable)
//   slave  : alarm_sequencer side (drives start_timer, siren, leds, state)
interface alarm_sequencer_if;
  logic       ignition;
  logic       driver_door;
  logic       passenger_door;
  logic       hidden_switch;
  logic       brake_pedal;
  logic       reprogram;
  logic [1:0] time_param_sel;
  logic [3:0] time_value;
  logic       one_hz_enable;
  logic       start_timer;
  logic       siren;
  logic       status_led;
  logic       fuel_pump_power;
  logic [2:0] fsm_state;
  logic [3:0] countdown;

  modport master (
    output ignition, driver_door, passenger_door, hidden_switch, brake_pedal,
    output reprogram, time_param_sel, time_value, one_hz_enable,
    input  start_timer, siren, status_led, fuel_pump_power, fsm_state, countdown
  );

  modport slave (
    input  ignition, driver_door, passenger_door, hidden_switch, brake_pedal,
    input  reprogram, time_param_sel, time_value, one_hz_enable,
    output start_timer, siren, status_led, fuel_pump_power, fsm_state, countdown
  );
endinterface

// File: rtl/alarm_sequencer.sv
// alarm_sequencer
//   Top-level control FSM of the vehicle anti-theft system. Drives the
//   shared 1 Hz divider restart (start_timer), runs a seconds countdown
//   loaded from four programmable delay registers, and decides arming,
//   trigger delay, siren, status LED and fuel pump power.
// Ports
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : alarm_sequencer_if.slave (sensors, reprogram bus,
//             one_hz_enable in; start_timer, siren, status_led,
//             fuel_pump_power, fsm_state, countdown out)
// Build option
//   ALARM_SEQ_FUEL_PUMP_EN : fuel pump needs ignition + hidden_switch +
//   brake_pedal to turn on; otherwise it simply follows ignition.
//
// state             | code | meaning
// ARMED             | 0    | armed, watching doors, LED blinks at 1 Hz
// TRIGGERED         | 1    | door opened, counting down the entry delay
// SOUND_ALARM       | 2    | siren on while any door is open
// ALARM_HOLD        | 3    | doors closed, siren held for alarm_on seconds
// DISARMED          | 4    | valid ignition, system off
// WAIT_DRIVER_OPEN  | 5    | ignition off, waiting for driver to leave
// WAIT_DRIVER_CLOSE | 6    | driver door open, waiting for it to close
// ARM_DELAY         | 7    | counting down before re-arming
module alarm_sequencer #(
  parameter logic [3:0] T_ARM_DELAY_RST       = 4'd6,
  parameter logic [3:0] T_DRIVER_DELAY_RST    = 4'd8,
  parameter logic [3:0] T_PASSENGER_DELAY_RST = 4'd15,
  parameter logic [3:0] T_ALARM_ON_RST        = 4'd10
) (
  input  logic               clk,
  input  logic               reset_n,
  alarm_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    ARMED             = 3'd0,
    TRIGGERED         = 3'd1,
    SOUND_ALARM       = 3'd2,
    ALARM_HOLD        = 3'd3,
    DISARMED          = 3'd4,
    WAIT_DRIVER_OPEN  = 3'd5,
    WAIT_DRIVER_CLOSE = 3'd6,
    ARM_DELAY         = 3'd7
  } state_t;

  localparam logic [1:0] SEL_ARM       = 2'd0;
  localparam logic [1:0] SEL_DRIVER    = 2'd1;
  localparam logic [1:0] SEL_PASSENGER = 2'd2;
  localparam logic [1:0] SEL_ALARM_ON  = 2'd3;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       run_q, run_d;
  logic       start_q, start_d;
  logic       siren_q, siren_d;
  logic       led_q, led_d;
  logic       fuel_q, fuel_d;
  logic [3:0] delay_q [4];

  logic       load_en;
  logic [3:0] load_val;
  logic       expired;
  logic       any_door;

  assign expired  = run_q && (cnt_q == 4'd0);
  assign any_door = bus.driver_door || bus.passenger_door;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ARMED;
      cnt_q    <= 4'd0;
      run_q    <= 1'b0;
      start_q  <= 1'b0;
      siren_q  <= 1'b0;
      led_q    <= 1'b0;
      fuel_q   <= 1'b0;
      delay_q[SEL_ARM]       <= T_ARM_DELAY_RST;
      delay_q[SEL_DRIVER]    <= T_DRIVER_DELAY_RST;
      delay_q[SEL_PASSENGER] <= T_PASSENGER_DELAY_RST;
      delay_q[SEL_ALARM_ON]  <= T_ALARM_ON_RST;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      start_q <= start_d;
      siren_q <= siren_d;
      led_q   <= led_d;
      fuel_q  <= fuel_d;
      if (bus.reprogram)
        delay_q[bus.time_param_sel] <= bus.time_value;
    end
  end

  // Next state; ignition is always checked before doors, doors before expiry.
  always_comb begin
    state_d  = state_q;
    load_en  = 1'b0;
    load_val = 4'd0;
    if (bus.reprogram) begin
      state_d = ARMED;
    end else begin
      case (state_q)
        ARMED: begin
          if (bus.ignition && bus.hidden_switch) begin
            state_d = DISARMED;
          end else if (bus.driver_door) begin
            state_d  = TRIGGERED;
            load_en  = 1'b1;
            load_val = delay_q[SEL_DRIVER];
          end else if (bus.passenger_door) begin
            state_d  = TRIGGERED;
            load_en  = 1'b1;
            load_val = delay_q[SEL_PASSENGER];
          end
        end
        TRIGGERED: begin
          if (bus.ignition)  state_d = DISARMED;
          else if (expired)  state_d = SOUND_ALARM;
        end
        SOUND_ALARM: begin
          if (!any_door) begin
            state_d  = ALARM_HOLD;
            load_en  = 1'b1;
            load_val = delay_q[SEL_ALARM_ON];
          end
        end
        ALARM_HOLD: begin
          if (any_door)      state_d = SOUND_ALARM;
          else if (expired)  state_d = ARMED;
        end
        DISARMED: begin
          if (!bus.ignition) state_d = WAIT_DRIVER_OPEN;
        end
        WAIT_DRIVER_OPEN: begin
          if (bus.ignition)         state_d = DISARMED;
          else if (bus.driver_door) state_d = WAIT_DRIVER_CLOSE;
        end
        WAIT_DRIVER_CLOSE: begin
          if (bus.ignition) begin
            state_d = DISARMED;
          end else if (!bus.driver_door) begin
            state_d  = ARM_DELAY;
            load_en  = 1'b1;
            load_val = delay_q[SEL_ARM];
          end
        end
        ARM_DELAY: begin
          if (bus.ignition)  state_d = DISARMED;
          else if (any_door) state_d = WAIT_DRIVER_CLOSE;
          else if (expired)  state_d = ARMED;
        end
        default: state_d = ARMED;
      endcase
    end
  end

  // Countdown and registered outputs. A transition that does not load a
  // delay stops the countdown so the display freezes at the last value.
  always_comb begin
    start_d = bus.reprogram || load_en;
    run_d   = run_q;
    cnt_d   = cnt_q;
    if (bus.reprogram) begin
      run_d = 1'b0;
    end else if (load_en) begin
      run_d = 1'b1;
      cnt_d = load_val;
    end else if (state_d != state_q) begin
      run_d = 1'b0;
    end else if (bus.one_hz_enable && run_q && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end

    siren_d = (state_d == SOUND_ALARM) || (state_d == ALARM_HOLD);

    led_d = 1'b0;
    case (state_d)
      ARMED:                             led_d = (state_q == ARMED) ? (led_q ^ bus.one_hz_enable) : 1'b0;
      TRIGGERED, SOUND_ALARM, ALARM_HOLD: led_d = 1'b1;
      default:                           led_d = 1'b0;
    endcase

`ifdef ALARM_SEQ_FUEL_PUMP_EN
    fuel_d = fuel_q;
    if (bus.ignition && bus.hidden_switch && bus.brake_pedal) fuel_d = 1'b1;
    else if (!bus.ignition)                                    fuel_d = 1'b0;
`else
    fuel_d = bus.ignition;
`endif
  end

  assign bus.start_timer     = start_q;
  assign bus.siren           = siren_q;
  assign bus.status_led      = led_q;
  assign bus.fuel_pump_power = fuel_q;
  assign bus.fsm_state       = state_q;
  assign bus.countdown       = cnt_q;

endmodule

// File: doc/alarm_sequencer.md
# alarm_sequencer

Top-level control FSM for the vehicle anti-theft system. It sequences the shared 1 Hz divider (issuing its `start_timer` restart pulse and consuming `one_hz_enable`) and an internal seconds countdown loaded from four programmable delay registers. From door, ignition and hidden-switch inputs it decides arming, trigger delay, siren and status LED.

## Interface
- `T_ARM_DELAY_RST`, 6: reset value of arm-delay register (s).
- `T_DRIVER_DELAY_RST`, 8: reset value of driver-door trigger delay (s).
- `T_PASSENGER_DELAY_RST`, 15: reset value of passenger-door trigger delay (s).
- `T_ALARM_ON_RST`, 10: reset value of post-close siren hold time (s).
- `clk` in 1: system clock. Ports are single clock; reset is asynchronous, active-low.
- `reset_n` in 1: async active-low reset.
- `ignition`, `driver_door`, `passenger_door`, `hidden_switch`, `brake_pedal` in 1 each: synchronized, debounced levels; door = 1 means open.
- `reprogram` in 1: single-cycle pulse that writes `time_value` into the register selected by `time_param_sel`.
- `time_param_sel` in 2: 0 arm, 1 driver, 2 passenger, 3 alarm_on.
- `time_value` in 4: new delay in seconds.
- `one_hz_enable` in 1: one-cycle tick from divider.
- `start_timer` out 1: one-cycle divider restart pulse, registered.
- `siren` out 1, `status_led` out 1, `fuel_pump_power` out 1.
- `fsm_state` out 3: state code for display. `countdown` out 4: remaining seconds.

## Operation
- States (code): ARMED 0, TRIGGERED 1, SOUND_ALARM 2, ALARM_HOLD 3, DISARMED 4, WAIT_DRIVER_OPEN 5, WAIT_DRIVER_CLOSE 6, ARM_DELAY 7.
- ARMED: driver_door → TRIGGERED loading driver delay; else passenger_door → TRIGGERED loading passenger delay; ignition (hidden_switch=1) → DISARMED.
- TRIGGERED: ignition → DISARMED; expired → SOUND_ALARM.
- SOUND_ALARM: both doors closed → ALARM_HOLD loading alarm_on.
- ALARM_HOLD: any door opens → SOUND_ALARM; expired → ARMED.
- DISARMED: ignition falls to 0 → WAIT_DRIVER_OPEN.
- WAIT_DRIVER_OPEN: driver_door → WAIT_DRIVER_CLOSE; ignition → DISARMED.
- WAIT_DRIVER_CLOSE: driver_door=0 → ARM_DELAY loading arm delay; ignition → DISARMED.
- ARM_DELAY: any door opens → WAIT_DRIVER_CLOSE; ignition → DISARMED; expired → ARMED.
- Every transition that loads a delay asserts `start_timer` for exactly one cycle and loads `countdown`; `running` is set.
- Countdown: on `one_hz_enable` && running && countdown≠0, decrement. `expired` = running && countdown==0. A load in the same cycle as a tick wins. A loaded value of 0 expires the next cycle.
- Outputs: `siren` = 1 in SOUND_ALARM and ALARM_HOLD. `status_led` toggles on each tick in ARMED, is steady 1 in TRIGGERED/SOUND_ALARM/ALARM_HOLD, and is 0 elsewhere.
- Reprogram: writes the selected register, forces the state to ARMED, clears running, and pulses `start_timer`. This has priority over all transitions.

## Timing
- Reset values: state ARMED, countdown 0, running 0, start_timer 0, siren 0, status_led 0, fuel_pump_power 0, delay registers at parameter values.
- State, countdown and outputs are registered. `start_timer` is high in the first cycle of the new state, and `countdown` shows the loaded value in that same cycle.
- The first decrement occurs on the first `one_hz_enable` after `start_timer`; the divider restarts its phase, so this is one full second later.
- Simultaneous events in one state resolve in order: reprogram > ignition > door > expired.
- Reset asserted mid-countdown returns to ARMED immediately (async), with no `start_timer` pulse.

## Configuration
- `ALARM_SEQ_FUEL_PUMP_EN` defined:
  - `fuel_pump_power` sets when ignition=1, hidden_switch=1 and brake_pedal=1 in the same cycle.
  - It clears when ignition=0.
- `ALARM_SEQ_FUEL_PUMP_EN` undefined: `fuel_pump_power` = `ignition` (registered), and `hidden_switch`/`brake_pedal` are ignored for it.

## Test plan
- Reset, then open driver_door → TRIGGERED, `start_timer` one cycle, countdown=8; with no ignition, 8 ticks later siren=1 (state 2).
- ARMED, passenger_door open, then ignition=1 after 3 ticks → DISARMED, siren never asserts, countdown stops at 12.
- SOUND_ALARM, close doors → ALARM_HOLD countdown=10; reopen at tick 4 → SOUND_ALARM; close and wait 10 ticks → ARMED, siren=0.
- Disarm, ignition off, open/close driver_door → ARM_DELAY countdown=6; open passenger door at tick 2 → WAIT_DRIVER_CLOSE; close → reload 6, ARMED after 6 ticks.
- reprogram with sel=1, value=3 → state ARMED, `start_timer` pulse; driver door → countdown=3, siren after 3 ticks. Value 0 → siren the cycle after TRIGGERED entry.
- Macro on: ignition+hidden_switch without brake → fuel_pump_power=0; add brake → 1; ignition off → 0.
